// File: rtl/core_ctrl_if.sv
// Signal bundle between the core controller and its datapath (PC, register file, ALU, imem).
// The master side is the controller; the slave side is the datapath/environment.
interface core_ctrl_if;
   logic        start;
   logic        pause;
   logic [7:0]  instruction;
   logic [7:0]  alu_out;

   logic [7:0]  ir;
   logic        pc_en;
   logic        branch_taken;
   logic [3:0]  branch_target;
   logic [1:0]  rf_ra1;
   logic [1:0]  rf_ra2;
   logic        rf_we;
   logic [1:0]  rf_wa;
   logic [7:0]  rf_wd;
   logic        zero_flag;
   logic        busy;
   logic        halted;
   logic [2:0]  state;
   logic [7:0]  instr_count;
   logic [15:0] cycle_count;

   modport master (
      input  start, pause, instruction, alu_out,
      output ir, pc_en, branch_taken, branch_target, rf_ra1, rf_ra2,
             rf_we, rf_wa, rf_wd, zero_flag, busy, halted, state,
             instr_count, cycle_count
   );

   modport slave (
      output start, pause, instruction, alu_out,
      input  ir, pc_en, branch_taken, branch_target, rf_ra1, rf_ra2,
             rf_we, rf_wa, rf_wd, zero_flag, busy, halted, state,
             instr_count, cycle_count
   );
endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle control FSM for a tiny 8-bit core: fetch, decode, execute, write-back,
// with JMP/BRZ/HALT resolved in decode, a pause freeze and saturating perf counters.
module core_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   core_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5,
      S_RSV6   = 3'd6,
      S_RSV7   = 3'd7
   } state_t;

   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_BRZ  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t      r_state;
   state_t      w_next_state;
   logic [7:0]  r_ir;
   logic [7:0]  r_result;
   logic        r_zero_flag;
   logic [7:0]  r_instr_count;
   logic [15:0] r_cycle_count;

   logic [3:0]  w_opcode;
   logic        w_busy;
   logic        w_pc_en;
   logic        w_branch_taken;
   logic        w_rf_we;
   logic        w_retire;

   assign w_opcode = r_ir[7:4];
   assign w_busy   = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                     (r_state == S_EXEC)  || (r_state == S_WB);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Strobes are pure decodes of state/ir gated by pause, so a frozen cycle never fires them.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_next_state   = r_state;
      w_pc_en        = 1'b0;
      w_branch_taken = 1'b0;
      w_rf_we        = 1'b0;
      w_retire       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!bus.pause && bus.start) w_next_state = S_FETCH;
         end
         S_FETCH: begin
            if (!bus.pause) w_next_state = S_DECODE;
         end
         S_DECODE: begin
            if (!bus.pause) begin
               case (w_opcode)
                  OP_HALT: begin
                     w_retire     = 1'b1;
                     w_next_state = S_HALTED;
                  end
                  OP_JMP: begin
                     w_pc_en        = 1'b1;
                     w_branch_taken = 1'b1;
                     w_retire       = 1'b1;
                     w_next_state   = S_FETCH;
                  end
                  OP_BRZ: begin
                     w_pc_en        = 1'b1;
                     w_branch_taken = r_zero_flag;
                     w_retire       = 1'b1;
                     w_next_state   = S_FETCH;
                  end
                  default: w_next_state = S_EXEC;
               endcase
            end
         end
         S_EXEC: begin
            if (!bus.pause) w_next_state = S_WB;
         end
         S_WB: begin
            if (!bus.pause) begin
               w_rf_we      = 1'b1;
               w_pc_en      = 1'b1;
               w_retire     = 1'b1;
               w_next_state = S_FETCH;
            end
         end
         S_HALTED: w_next_state = S_HALTED;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ir          <= 8'h00;
         r_result      <= 8'h00;
         r_zero_flag   <= 1'b0;
         r_instr_count <= 8'h00;
         r_cycle_count <= 16'h0000;
      end else begin
         if (r_state == S_FETCH && !bus.pause) r_ir <= bus.instruction;
         if (r_state == S_EXEC && !bus.pause) begin
            r_result    <= bus.alu_out;
            r_zero_flag <= (bus.alu_out == 8'h00);
         end
         if (w_retire && r_instr_count != 8'hFF) r_instr_count <= r_instr_count + 8'd1;
         // Busy cycles count through pause as well; both counters stick at all-ones.
         if (w_busy && r_cycle_count != 16'hFFFF) r_cycle_count <= r_cycle_count + 16'd1;
      end
   end

   assign bus.ir            = r_ir;
   assign bus.pc_en         = w_pc_en;
   assign bus.branch_taken  = w_branch_taken;
   assign bus.branch_target = r_ir[3:0];
   assign bus.rf_ra1        = r_ir[1:0];
   assign bus.rf_ra2        = r_ir[3:2];
   assign bus.rf_we         = w_rf_we;
   assign bus.rf_wa         = r_ir[3:2];
   assign bus.rf_wd         = r_result;
   assign bus.zero_flag     = r_zero_flag;
   assign bus.busy          = w_busy;
   assign bus.halted        = (r_state == S_HALTED);
   assign bus.state         = r_state;
   assign bus.instr_count   = r_instr_count;
   assign bus.cycle_count   = r_cycle_count;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: a table of single instructions run back to back, then
// hand-written halt, pause, mid-instruction reset and counter-saturation sequences.
module tb_core_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   core_ctrl_if bus ();

   core_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] instr;
      logic [7:0] alu;
      int         cycles;
      int         pc_cnt;
      logic       bt;
      logic       we;
      logic [1:0] wa;
      logic [7:0] wd;
      logic [3:0] target;
      logic       zero;
      logic [2:0] end_state;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic start_pulse();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      int         n;
      int         pc_cnt;
      logic       bt_seen;
      logic       we_seen;
      logic [1:0] wa_seen;
      logic [7:0] wd_seen;
      logic [3:0] tgt_seen;
      logic [7:0] e_ir;
      logic [15:0] cc0;

      checks = 0;
      errors = 0;
      rst_n           = 1'b0;
      bus.start       = 1'b0;
      bus.pause       = 1'b0;
      bus.instruction = 8'h00;
      bus.alu_out     = 8'h00;

      //            instr  alu    cyc pc bt    we    wa     wd     tgt    zero  end
      vecs[0] = '{8'h15, 8'h00, 4, 1, 1'b0, 1'b1, 2'd1, 8'h00, 4'h5, 1'b1, 3'd1};
      vecs[1] = '{8'hE9, 8'h77, 2, 1, 1'b1, 1'b0, 2'd0, 8'h00, 4'h9, 1'b1, 3'd1};
      vecs[2] = '{8'h2B, 8'h5A, 4, 1, 1'b0, 1'b1, 2'd2, 8'h5A, 4'hB, 1'b0, 3'd1};
      vecs[3] = '{8'hE9, 8'h00, 2, 1, 1'b0, 1'b0, 2'd0, 8'h00, 4'h9, 1'b0, 3'd1};
      vecs[4] = '{8'hD3, 8'h00, 2, 1, 1'b1, 1'b0, 2'd0, 8'h00, 4'h3, 1'b0, 3'd1};
      vecs[5] = '{8'h3C, 8'hFF, 4, 1, 1'b0, 1'b1, 2'd3, 8'hFF, 4'hC, 1'b0, 3'd1};
      vecs[6] = '{8'h40, 8'h00, 4, 1, 1'b0, 1'b1, 2'd0, 8'h00, 4'h0, 1'b1, 3'd1};
      vecs[7] = '{8'hD7, 8'h12, 2, 1, 1'b1, 1'b0, 2'd0, 8'h00, 4'h7, 1'b1, 3'd1};
      vecs[8] = '{8'hF0, 8'h34, 2, 0, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 3'd5};

      // Reset values without any clock edge yet
      #3;
      check("rst_state", bus.state, 3'd0);
      check("rst_ir", bus.ir, 8'h00);
      check("rst_zero", bus.zero_flag, 1'b0);
      check("rst_icnt", bus.instr_count, 8'h00);
      check("rst_ccnt", bus.cycle_count, 16'h0000);
      check("rst_strobes", {bus.pc_en, bus.branch_taken, bus.rf_we, bus.busy, bus.halted}, 5'b0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_without_start", bus.state, 3'd0);

      start_pulse();
      check("start_to_fetch", bus.state, 3'd1);

      for (int i = 0; i < 9; i++) begin
         bus.instruction = vecs[i].instr;
         bus.alu_out     = vecs[i].alu;
         check($sformatf("v%0d_in_fetch", i), bus.state, 3'd1);
         n = 0; pc_cnt = 0; bt_seen = 0; we_seen = 0;
         wa_seen = 0; wd_seen = 0; tgt_seen = 0;
         do begin
            if (bus.pc_en) begin
               pc_cnt++;
               tgt_seen = bus.branch_target;
               if (bus.branch_taken) bt_seen = 1'b1;
            end
            if (bus.rf_we) begin
               we_seen = 1'b1;
               wa_seen = bus.rf_wa;
               wd_seen = bus.rf_wd;
            end
            tick();
            n++;
         end while (n < 10 && bus.state != 3'd1 && bus.state != 3'd5);
         e_ir = vecs[i].instr;
         check($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
         check($sformatf("v%0d_end_state", i), bus.state, vecs[i].end_state);
         check($sformatf("v%0d_pc_en_count", i), pc_cnt, vecs[i].pc_cnt);
         check($sformatf("v%0d_branch_taken", i), bt_seen, vecs[i].bt);
         check($sformatf("v%0d_rf_we", i), we_seen, vecs[i].we);
         if (vecs[i].we) begin
            check($sformatf("v%0d_rf_wa", i), wa_seen, vecs[i].wa);
            check($sformatf("v%0d_rf_wd", i), wd_seen, vecs[i].wd);
         end
         if (vecs[i].pc_cnt != 0)
            check($sformatf("v%0d_target", i), tgt_seen, vecs[i].target);
         check($sformatf("v%0d_zero", i), bus.zero_flag, vecs[i].zero);
         check($sformatf("v%0d_icnt", i), bus.instr_count, i + 1);
         check($sformatf("v%0d_ir", i), bus.ir, e_ir);
         check($sformatf("v%0d_ra1", i), bus.rf_ra1, e_ir[1:0]);
         check($sformatf("v%0d_ra2", i), bus.rf_ra2, e_ir[3:2]);
      end

      // Halted: persists, ignores start, counters frozen
      check("halt_halted", bus.halted, 1'b1);
      check("halt_busy", bus.busy, 1'b0);
      check("halt_ccnt", bus.cycle_count, 16'd26);
      start_pulse();
      tick();
      tick();
      check("halt_state_after_start", bus.state, 3'd5);
      check("halt_icnt_after_start", bus.instr_count, 8'd9);
      check("halt_ccnt_after_start", bus.cycle_count, 16'd26);

      // Pause for three cycles in EXEC
      do_reset();
      bus.instruction = 8'h2B;
      bus.alu_out     = 8'h01;
      start_pulse();
      tick();
      tick();
      check("pause_in_exec", bus.state, 3'd3);
      bus.pause = 1'b1;
      cc0 = bus.cycle_count;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("pause_rf_we_%0d", k), bus.rf_we, 1'b0);
         tick();
         check($sformatf("pause_state_%0d", k), bus.state, 3'd3);
      end
      check("pause_ccnt_adv", bus.cycle_count, cc0 + 16'd3);
      check("pause_icnt_held", bus.instr_count, 8'd0);
      bus.pause = 1'b0;
      tick();
      check("pause_wb_state", bus.state, 3'd4);
      check("pause_wb_we", bus.rf_we, 1'b1);
      check("pause_wb_wd", bus.rf_wd, 8'h01);
      check("pause_wb_zero", bus.zero_flag, 1'b0);
      bus.pause = 1'b1;
      #1;
      check("pause_in_wb_strobes", {bus.rf_we, bus.pc_en}, 2'b00);
      tick();
      check("pause_in_wb_hold", bus.state, 3'd4);
      bus.pause = 1'b0;
      tick();
      check("pause_done_fetch", bus.state, 3'd1);
      check("pause_done_icnt", bus.instr_count, 8'd1);

      // Reset asserted in the middle of WB
      do_reset();
      bus.instruction = 8'h15;
      bus.alu_out     = 8'h00;
      start_pulse();
      tick();
      tick();
      tick();
      check("wb_before_reset", {bus.rf_we, bus.pc_en, bus.rf_wa}, {1'b1, 1'b1, 2'd1});
      check("wb_zero_before_reset", bus.zero_flag, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_strobes", {bus.rf_we, bus.pc_en, bus.busy, bus.halted}, 4'b0);
      check("async_rst_state", bus.state, 3'd0);
      check("async_rst_ir_zero", {bus.ir, 7'd0, bus.zero_flag}, 16'h0000);
      check("async_rst_counts", {bus.instr_count, bus.cycle_count}, 24'h0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      check("post_rst_idle", bus.state, 3'd0);
      check("post_rst_ccnt", bus.cycle_count, 16'd0);

      // 300 JMPs: instruction count saturates
      bus.instruction = 8'hD0;
      start_pulse();
      repeat (600) tick();
      check("sat_icnt", bus.instr_count, 8'hFF);
      check("sat_ccnt", bus.cycle_count, 16'd600);
      check("sat_state", bus.state, 3'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
